// File: rtl/axi3_reg_slice.sv
// axi3_reg_slice
//   One pipeline stage on each AXI3 channel (AW, W, B, AR, R) between the
//   slave-side port s_* (toward the traffic master) and the master-side
//   port m_* (toward the HBM pseudo-channel). Each channel is set up on
//   its own as BYPASS (0), FULL (1, 2-entry skid) or FWD (2, 1-entry).
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   s_aw*/s_w*/s_ar*         request channels in from the master
//   m_aw*/m_w*/m_ar*         request channels out to the HBM port
//   m_b*/m_r*                response channels in from the HBM port
//   s_b*/s_r*                response channels out to the master
//   busy_o                   some FULL/FWD stage holds at least one beat
//
// FULL stage states
//   state    | meaning
//   ST_EMPTY | no beat held, downstream valid low
//   ST_ONE   | one beat in main, upstream ready high
//   ST_TWO   | main and skid both full, upstream ready low
module axi3_reg_slice #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int AW_MODE    = 1,
    parameter int W_MODE     = 1,
    parameter int B_MODE     = 1,
    parameter int AR_MODE    = 1,
    parameter int R_MODE     = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ID_WIDTH-1:0]     s_awid_i,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
    input  logic [3:0]              s_awlen_i,
    input  logic [2:0]              s_awsize_i,
    input  logic [1:0]              s_awburst_i,
    input  logic [1:0]              s_awlock_i,
    input  logic [3:0]              s_awcache_i,
    input  logic [2:0]              s_awprot_i,
    input  logic [3:0]              s_awqos_i,
    input  logic                    s_awvalid_i,
    output logic                    s_awready_o,
    input  logic [DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
    input  logic                    s_wlast_i,
    input  logic                    s_wvalid_i,
    output logic                    s_wready_o,
    output logic [ID_WIDTH-1:0]     s_bid_o,
    output logic [1:0]              s_bresp_o,
    output logic                    s_bvalid_o,
    input  logic                    s_bready_i,
    input  logic [ID_WIDTH-1:0]     s_arid_i,
    input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
    input  logic [3:0]              s_arlen_i,
    input  logic [2:0]              s_arsize_i,
    input  logic [1:0]              s_arburst_i,
    input  logic [1:0]              s_arlock_i,
    input  logic [3:0]              s_arcache_i,
    input  logic [2:0]              s_arprot_i,
    input  logic [3:0]              s_arqos_i,
    input  logic                    s_arvalid_i,
    output logic                    s_arready_o,
    output logic [ID_WIDTH-1:0]     s_rid_o,
    output logic [DATA_WIDTH-1:0]   s_rdata_o,
    output logic [1:0]              s_rresp_o,
    output logic                    s_rlast_o,
    output logic                    s_rvalid_o,
    input  logic                    s_rready_i,
    output logic [ID_WIDTH-1:0]     m_awid_o,
    output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
    output logic [3:0]              m_awlen_o,
    output logic [2:0]              m_awsize_o,
    output logic [1:0]              m_awburst_o,
    output logic [1:0]              m_awlock_o,
    output logic [3:0]              m_awcache_o,
    output logic [2:0]              m_awprot_o,
    output logic [3:0]              m_awqos_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
    output logic                    m_wlast_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [ID_WIDTH-1:0]     m_bid_i,
    input  logic [1:0]              m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    output logic [ID_WIDTH-1:0]     m_arid_o,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [3:0]              m_arlen_o,
    output logic [2:0]              m_arsize_o,
    output logic [1:0]              m_arburst_o,
    output logic [1:0]              m_arlock_o,
    output logic [3:0]              m_arcache_o,
    output logic [2:0]              m_arprot_o,
    output logic [3:0]              m_arqos_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [ID_WIDTH-1:0]     m_rid_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i,
    input  logic                    m_rlast_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    output logic                    busy_o
);

    localparam int AXW = ID_WIDTH + ADDR_WIDTH + 22;
    localparam int WW  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int BW  = ID_WIDTH + 2;
    localparam int RW  = ID_WIDTH + DATA_WIDTH + 3;

    // Channel index: 0=AW, 1=W, 2=B, 3=AR, 4=R
    function automatic int ch_width(input int c);
        case (c)
            0:       return AXW;
            1:       return WW;
            2:       return BW;
            3:       return AXW;
            default: return RW;
        endcase
    endfunction

    function automatic int ch_mode(input int c);
        case (c)
            0:       return AW_MODE;
            1:       return W_MODE;
            2:       return B_MODE;
            3:       return AR_MODE;
            default: return R_MODE;
        endcase
    endfunction

    // Next-cycle occupancy per channel; busy is registered from it so it
    // has no combinational input.
    logic [4:0] hold_d;
    logic       busy_q;

    for (genvar c = 0; c < 5; c++) begin : g_ch
        localparam int PW   = ch_width(c);
        localparam int MODE = ch_mode(c);

        logic [PW-1:0] in_pl;
        logic [PW-1:0] out_pl;
        logic          in_valid;
        logic          in_ready;
        logic          out_valid;
        logic          out_ready;

        if (c == 0) begin : g_aw
            assign in_pl       = {s_awid_i, s_awaddr_i, s_awlen_i, s_awsize_i, s_awburst_i,
                                  s_awlock_i, s_awcache_i, s_awprot_i, s_awqos_i};
            assign in_valid    = s_awvalid_i;
            assign s_awready_o = in_ready;
            assign {m_awid_o, m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o,
                    m_awlock_o, m_awcache_o, m_awprot_o, m_awqos_o} = out_pl;
            assign m_awvalid_o = out_valid;
            assign out_ready   = m_awready_i;
        end else if (c == 1) begin : g_w
            assign in_pl      = {s_wdata_i, s_wstrb_i, s_wlast_i};
            assign in_valid   = s_wvalid_i;
            assign s_wready_o = in_ready;
            assign {m_wdata_o, m_wstrb_o, m_wlast_o} = out_pl;
            assign m_wvalid_o = out_valid;
            assign out_ready  = m_wready_i;
        end else if (c == 2) begin : g_b
            assign in_pl      = {m_bid_i, m_bresp_i};
            assign in_valid   = m_bvalid_i;
            assign m_bready_o = in_ready;
            assign {s_bid_o, s_bresp_o} = out_pl;
            assign s_bvalid_o = out_valid;
            assign out_ready  = s_bready_i;
        end else if (c == 3) begin : g_ar
            assign in_pl       = {s_arid_i, s_araddr_i, s_arlen_i, s_arsize_i, s_arburst_i,
                                  s_arlock_i, s_arcache_i, s_arprot_i, s_arqos_i};
            assign in_valid    = s_arvalid_i;
            assign s_arready_o = in_ready;
            assign {m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o,
                    m_arlock_o, m_arcache_o, m_arprot_o, m_arqos_o} = out_pl;
            assign m_arvalid_o = out_valid;
            assign out_ready   = m_arready_i;
        end else begin : g_r
            assign in_pl      = {m_rid_i, m_rdata_i, m_rresp_i, m_rlast_i};
            assign in_valid   = m_rvalid_i;
            assign m_rready_o = in_ready;
            assign {s_rid_o, s_rdata_o, s_rresp_o, s_rlast_o} = out_pl;
            assign s_rvalid_o = out_valid;
            assign out_ready  = s_rready_i;
        end

        if (MODE == 0) begin : g_bypass
            assign out_pl    = in_pl;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign hold_d[c] = 1'b0;
        end else if (MODE == 1) begin : g_full
            localparam logic [1:0] ST_EMPTY = 2'd0;
            localparam logic [1:0] ST_ONE   = 2'd1;
            localparam logic [1:0] ST_TWO   = 2'd2;

            logic [1:0]    state_q, state_d;
            logic          rdy_q;
            logic [PW-1:0] main_q, main_d;
            logic [PW-1:0] skid_q, skid_d;
            logic          in_xfer;
            logic          out_xfer;

            assign in_xfer  = in_valid & rdy_q;
            assign out_xfer = out_ready & (state_q != ST_EMPTY);

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (in_xfer) begin
                            state_d = ST_ONE;
                            main_d  = in_pl;
                        end
                    end
                    ST_ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_d = in_pl;
                        end else if (in_xfer) begin
                            state_d = ST_TWO;
                            skid_d  = in_pl;
                        end else if (out_xfer) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        // rdy_q is low here, so only the drain can happen
                        if (out_xfer) begin
                            state_d = ST_ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_q <= ST_EMPTY;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    rdy_q   <= (state_d != ST_TWO);
                end
            end

            always_ff @(posedge clk_i) begin
                main_q <= main_d;
                skid_q <= skid_d;
            end

            assign out_valid = (state_q != ST_EMPTY);
            assign out_pl    = main_q;
            assign in_ready  = rdy_q;
            assign hold_d[c] = (state_d != ST_EMPTY);
        end else begin : g_fwd
            logic          valid_q;
            logic          valid_d;
            logic [PW-1:0] data_q;

            // A new beat may load in the same cycle the held one leaves.
            assign in_ready = ~valid_q | out_ready;
            assign valid_d  = (in_valid & in_ready) | (valid_q & ~out_ready);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
            end

            always_ff @(posedge clk_i) begin
                if (in_valid & in_ready) begin
                    data_q <= in_pl;
                end
            end

            assign out_valid = valid_q;
            assign out_pl    = data_q;
            assign hold_d[c] = valid_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |hold_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_axi3_reg_slice.sv
module tb_axi3_reg_slice;

    localparam int IDW   = 6;
    localparam int ADW   = 33;
    localparam int DW    = 64;
    localparam int SW    = DW / 8;
    localparam int AXW   = IDW + ADW + 22;
    localparam int WW    = DW + SW + 1;
    localparam int BW    = IDW + 2;
    localparam int RW    = IDW + DW + 3;
    localparam int PWMAX = 80;
    // AW=BYPASS, W=FULL, B=FWD, AR=FULL, R=FWD
    localparam int MODE_TAB [5] = '{0, 1, 2, 1, 2};

    logic clk;
    logic rst;

    logic [AXW-1:0] s_aw_pl, s_ar_pl;
    logic           s_awvalid, s_arvalid;
    wire            s_awready, s_arready;
    wire  [AXW-1:0] m_aw_pl, m_ar_pl;
    wire            m_awvalid, m_arvalid;
    logic           m_awready, m_arready;
    logic [WW-1:0]  s_w_pl;
    logic           s_wvalid;
    wire            s_wready;
    wire  [WW-1:0]  m_w_pl;
    wire            m_wvalid;
    logic           m_wready;
    logic [BW-1:0]  m_b_pl;
    logic           m_bvalid;
    wire            m_bready;
    wire  [BW-1:0]  s_b_pl;
    wire            s_bvalid;
    logic           s_bready;
    logic [RW-1:0]  m_r_pl;
    logic           m_rvalid;
    wire            m_rready;
    wire  [RW-1:0]  s_r_pl;
    wire            s_rvalid;
    logic           s_rready;
    wire            busy;

    axi3_reg_slice #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW),
        .AW_MODE(0), .W_MODE(1), .B_MODE(2), .AR_MODE(1), .R_MODE(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_awid_i(s_aw_pl[60:55]), .s_awaddr_i(s_aw_pl[54:22]), .s_awlen_i(s_aw_pl[21:18]),
        .s_awsize_i(s_aw_pl[17:15]), .s_awburst_i(s_aw_pl[14:13]), .s_awlock_i(s_aw_pl[12:11]),
        .s_awcache_i(s_aw_pl[10:7]), .s_awprot_i(s_aw_pl[6:4]), .s_awqos_i(s_aw_pl[3:0]),
        .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
        .s_wdata_i(s_w_pl[72:9]), .s_wstrb_i(s_w_pl[8:1]), .s_wlast_i(s_w_pl[0]),
        .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
        .s_bid_o(s_b_pl[7:2]), .s_bresp_o(s_b_pl[1:0]), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
        .s_arid_i(s_ar_pl[60:55]), .s_araddr_i(s_ar_pl[54:22]), .s_arlen_i(s_ar_pl[21:18]),
        .s_arsize_i(s_ar_pl[17:15]), .s_arburst_i(s_ar_pl[14:13]), .s_arlock_i(s_ar_pl[12:11]),
        .s_arcache_i(s_ar_pl[10:7]), .s_arprot_i(s_ar_pl[6:4]), .s_arqos_i(s_ar_pl[3:0]),
        .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
        .s_rid_o(s_r_pl[72:67]), .s_rdata_o(s_r_pl[66:3]), .s_rresp_o(s_r_pl[2:1]), .s_rlast_o(s_r_pl[0]),
        .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
        .m_awid_o(m_aw_pl[60:55]), .m_awaddr_o(m_aw_pl[54:22]), .m_awlen_o(m_aw_pl[21:18]),
        .m_awsize_o(m_aw_pl[17:15]), .m_awburst_o(m_aw_pl[14:13]), .m_awlock_o(m_aw_pl[12:11]),
        .m_awcache_o(m_aw_pl[10:7]), .m_awprot_o(m_aw_pl[6:4]), .m_awqos_o(m_aw_pl[3:0]),
        .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
        .m_wdata_o(m_w_pl[72:9]), .m_wstrb_o(m_w_pl[8:1]), .m_wlast_o(m_w_pl[0]),
        .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
        .m_bid_i(m_b_pl[7:2]), .m_bresp_i(m_b_pl[1:0]), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
        .m_arid_o(m_ar_pl[60:55]), .m_araddr_o(m_ar_pl[54:22]), .m_arlen_o(m_ar_pl[21:18]),
        .m_arsize_o(m_ar_pl[17:15]), .m_arburst_o(m_ar_pl[14:13]), .m_arlock_o(m_ar_pl[12:11]),
        .m_arcache_o(m_ar_pl[10:7]), .m_arprot_o(m_ar_pl[6:4]), .m_arqos_o(m_ar_pl[3:0]),
        .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
        .m_rid_i(m_r_pl[72:67]), .m_rdata_i(m_r_pl[66:3]), .m_rresp_i(m_r_pl[2:1]), .m_rlast_i(m_r_pl[0]),
        .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic checkp(input string name, input logic [PWMAX-1:0] act, input logic [PWMAX-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic string cname(input int c);
        case (c)
            0:       return "aw";
            1:       return "w";
            2:       return "b";
            3:       return "ar";
            default: return "r";
        endcase
    endfunction

    // Model: each stage is a bounded FIFO of depth 0 (bypass), 2 (full) or 1 (fwd).
    logic [PWMAX-1:0] mdl [5][2];
    int               occ [5];

    task automatic model_chan(input int c, input logic iv, input logic ir, input logic [PWMAX-1:0] ipl,
                              input logic ov, input logic orr, input logic [PWMAX-1:0] opl);
        logic exp_ir, pop, push;
        if (MODE_TAB[c] == 0) begin
            check1({cname(c), "_byp_valid"}, ov, iv);
            check1({cname(c), "_byp_ready"}, ir, orr);
            if (iv) checkp({cname(c), "_byp_payload"}, opl, ipl);
        end else begin
            check1({cname(c), "_valid"}, ov, occ[c] > 0);
            if (occ[c] > 0) checkp({cname(c), "_payload"}, opl, mdl[c][0]);
            exp_ir = (MODE_TAB[c] == 1) ? (occ[c] < 2) : (occ[c] == 0 || orr);
            check1({cname(c), "_ready"}, ir, exp_ir);
            pop  = (occ[c] > 0) && orr;
            push = iv && exp_ir;
            if (pop) begin
                mdl[c][0] = mdl[c][1];
                occ[c]--;
            end
            if (push) begin
                mdl[c][occ[c]] = ipl;
                occ[c]++;
            end
        end
    endtask

    logic [DW-1:0] r_data [256];
    logic          r_mon = 1'b0;
    int            r_rx  = 0;

    always @(negedge clk) begin
        if (rst) begin
            check1("rst_m_wvalid", m_wvalid, 1'b0);
            check1("rst_s_bvalid", s_bvalid, 1'b0);
            check1("rst_m_arvalid", m_arvalid, 1'b0);
            check1("rst_s_rvalid", s_rvalid, 1'b0);
            check1("rst_busy", busy, 1'b0);
            check1("rst_s_wready", s_wready, 1'b1);
            check1("rst_m_bready", m_bready, 1'b1);
            check1("rst_s_arready", s_arready, 1'b1);
            check1("rst_m_rready", m_rready, 1'b1);
            for (int c = 0; c < 5; c++) occ[c] = 0;
        end else begin
            if (r_mon && s_rvalid && s_rready && r_rx < 256) begin
                checkp("r_order", {7'b0, s_r_pl},
                       {7'b0, 6'(r_rx), r_data[r_rx], 2'(r_rx % 4), (r_rx % 8 == 7)});
                r_rx++;
            end
            check1("busy", busy, (occ[1] > 0) || (occ[2] > 0) || (occ[3] > 0) || (occ[4] > 0));
            model_chan(0, s_awvalid, s_awready, {19'b0, s_aw_pl}, m_awvalid, m_awready, {19'b0, m_aw_pl});
            model_chan(1, s_wvalid, s_wready, {7'b0, s_w_pl}, m_wvalid, m_wready, {7'b0, m_w_pl});
            model_chan(2, m_bvalid, m_bready, {72'b0, m_b_pl}, s_bvalid, s_bready, {72'b0, s_b_pl});
            model_chan(3, s_arvalid, s_arready, {19'b0, s_ar_pl}, m_arvalid, m_arready, {19'b0, m_ar_pl});
            model_chan(4, m_rvalid, m_rready, {7'b0, m_r_pl}, s_rvalid, s_rready, {7'b0, s_r_pl});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AXW-1:0] ar_beat(input int k);
        return {6'(10 + k), 33'h1_2345_6000 + 33'(k * 64), 4'd3, 3'd5, 2'd1, 2'd0, 4'd2, 3'd0, 4'(k)};
    endfunction

    function automatic logic [95:0] r96();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] rnd;
        logic [31:0] rb;
        logic        fire;
        int          i;
        int          guard;

        rst = 1'b1;
        s_aw_pl = '0; s_ar_pl = '0; s_w_pl = '0; m_b_pl = '0; m_r_pl = '0;
        s_awvalid = 1'b0; s_wvalid = 1'b0; m_bvalid = 1'b0; s_arvalid = 1'b0; m_rvalid = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1; s_bready = 1'b1; m_arready = 1'b1; s_rready = 1'b1;
        for (int k = 0; k < 256; k++) r_data[k] = {$urandom, $urandom};
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Streaming 16-beat W burst, FULL, downstream always ready
        check1("w_stream_idle", m_wvalid, 1'b0);
        for (int k = 0; k < 16; k++) begin
            s_wvalid = 1'b1;
            s_w_pl   = {64'hA000_0000 + 64'(k), 8'hFF, (k == 15)};
            check1("w_stream_sready", s_wready, 1'b1);
            tick();
            check1("w_stream_mvalid", m_wvalid, 1'b1);
            checkp("w_stream_data", {7'b0, m_w_pl}, {7'b0, 64'hA000_0000 + 64'(k), 8'hFF, (k == 15)});
        end
        s_wvalid = 1'b0;
        tick();
        check1("w_stream_end", m_wvalid, 1'b0);

        // AR backpressure, FULL: only two beats fit
        m_arready = 1'b0;
        s_arvalid = 1'b1;
        s_ar_pl   = ar_beat(0);
        check1("ar_bp_rdy0", s_arready, 1'b1);
        tick();
        s_ar_pl = ar_beat(1);
        check1("ar_bp_rdy1", s_arready, 1'b1);
        tick();
        s_ar_pl = ar_beat(2);
        check1("ar_bp_full", s_arready, 1'b0);
        check1("ar_bp_busy", busy, 1'b1);
        tick();
        check1("ar_bp_hold", s_arready, 1'b0);
        checkp("ar_bp_a0", {19'b0, m_ar_pl}, {19'b0, ar_beat(0)});
        m_arready = 1'b1;
        tick();
        check1("ar_bp_reopen", s_arready, 1'b1);
        checkp("ar_bp_a1", {19'b0, m_ar_pl}, {19'b0, ar_beat(1)});
        tick();
        check1("ar_bp_a2_valid", m_arvalid, 1'b1);
        checkp("ar_bp_a2", {19'b0, m_ar_pl}, {19'b0, ar_beat(2)});
        s_arvalid = 1'b0;
        tick();
        check1("ar_bp_drained", m_arvalid, 1'b0);

        // R channel, FWD, random downstream ready over 256 beats
        r_mon = 1'b1;
        i = 0;
        guard = 0;
        while (i < 256 && guard < 4000) begin
            m_rvalid = 1'b1;
            m_r_pl   = {6'(i), r_data[i], 2'(i % 4), (i % 8 == 7)};
            s_rready = 1'($urandom_range(0, 1));
            #1;
            fire = m_rready;
            tick();
            if (fire) i++;
            guard++;
        end
        check1("r_all_sent", i == 256, 1'b1);
        m_rvalid = 1'b0;
        s_rready = 1'b1;
        tick();
        tick();
        r_mon = 1'b0;
        check1("r_rx_count", r_rx == 256, 1'b1);

        // Mixed: AW bypass same cycle, W FULL +1, B FWD +1
        s_awvalid = 1'b1;
        s_aw_pl   = {6'h15, 33'h1_DEAD_BEE0, 4'd3, 3'd5, 2'd1, 2'd0, 4'd3, 3'd2, 4'd0};
        m_awready = 1'b0;
        #1;
        check1("mix_aw_valid", m_awvalid, 1'b1);
        checkp("mix_aw_payload", {19'b0, m_aw_pl},
               {19'b0, 6'h15, 33'h1_DEAD_BEE0, 4'd3, 3'd5, 2'd1, 2'd0, 4'd3, 3'd2, 4'd0});
        check1("mix_aw_ready_lo", s_awready, 1'b0);
        m_awready = 1'b1;
        #1;
        check1("mix_aw_ready_hi", s_awready, 1'b1);
        tick();
        s_awvalid = 1'b0;
        #1;
        check1("mix_aw_gone", m_awvalid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            s_wvalid = 1'b1;
            s_w_pl   = {64'hB000_0000 + 64'(k), 8'h0F, (k == 3)};
            #1;
            check1("mix_w_not_yet", m_wvalid, k != 0);
            tick();
            checkp("mix_w_data", {7'b0, m_w_pl}, {7'b0, 64'hB000_0000 + 64'(k), 8'h0F, (k == 3)});
        end
        s_wvalid = 1'b0;
        tick();
        m_bvalid = 1'b1;
        m_b_pl   = {6'h2A, 2'b01};
        #1;
        check1("mix_b_not_yet", s_bvalid, 1'b0);
        tick();
        check1("mix_b_valid", s_bvalid, 1'b1);
        checkp("mix_b_payload", {72'b0, s_b_pl}, {72'b0, 6'h2A, 2'b01});
        m_bvalid = 1'b0;
        tick();
        check1("mix_b_gone", s_bvalid, 1'b0);

        // Reset while AR holds two beats
        m_arready = 1'b0;
        s_arvalid = 1'b1;
        s_ar_pl   = ar_beat(5);
        tick();
        s_ar_pl = ar_beat(6);
        tick();
        s_arvalid = 1'b0;
        check1("rst_pre_busy", busy, 1'b1);
        check1("rst_pre_valid", m_arvalid, 1'b1);
        rst = 1'b1;
        #1;
        check1("rst_async_valid", m_arvalid, 1'b0);
        check1("rst_async_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        check1("rst_rel_ready", s_arready, 1'b1);
        m_arready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("rst_no_stale", m_arvalid, 1'b0);
        end

        // Random soak on all channels
        for (int k = 0; k < 10000; k++) begin
            rb = $urandom;
            s_awvalid = rb[0]; s_wvalid = rb[1]; m_bvalid = rb[2]; s_arvalid = rb[3]; m_rvalid = rb[4];
            m_awready = rb[5]; m_wready = rb[6]; s_bready = rb[7]; m_arready = rb[8]; s_rready = rb[9];
            rnd = r96(); s_aw_pl = rnd[AXW-1:0];
            rnd = r96(); s_w_pl  = rnd[WW-1:0];
            rnd = r96(); m_b_pl  = rnd[BW-1:0];
            rnd = r96(); s_ar_pl = rnd[AXW-1:0];
            rnd = r96(); m_r_pl  = rnd[RW-1:0];
            tick();
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; m_bvalid = 1'b0; s_arvalid = 1'b0; m_rvalid = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1; s_bready = 1'b1; m_arready = 1'b1; s_rready = 1'b1;
        repeat (6) tick();
        check1("soak_busy_drained", busy, 1'b0);
        check1("soak_w_drained", m_wvalid, 1'b0);
        check1("soak_r_drained", s_rvalid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
